uart_rx_os: RTL and testbench

//  Single-clock, 16x-oversampled UART receiver: the far end of the serial line driven by the UART transmitter.

---
 rtl/uart_rx_os_pkg.sv | 29 ++
 rtl/uart_rx_os_if.sv | 26 ++
 rtl/uart_rx_os_baud_tick.sv | 54 +++++
 rtl/uart_rx_os.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver.
//   rx_state_e  : receiver FSM states
//   OVERSAMPLE  : ticks per bit window
//   VOTE_SC     : sample-counter value at which the majority vote is taken
//   DEF_DIV_*   : default prescaler divisors (50 MHz board clock)
//   maj3        : 2-of-3 majority helper
package uart_rx_os_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned VOTE_SC    = 9;

    localparam int unsigned DEF_DIV_0 = 326;
    localparam int unsigned DEF_DIV_1 = 163;
    localparam int unsigned DEF_DIV_2 = 54;
    localparam int unsigned DEF_DIV_3 = 27;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Consumer-side bus of the UART receiver: holding register, handshake and status.
//   Received : holding register byte        rx_valid : holding register full
//   rx_ack   : consumer pops the register   rx_Done  : 1-clk pulse on frame commit
//   rx_Busy  : frame in progress            Error    : framing error pulse
//   par_err  : parity error pulse           overrun  : sticky overrun flag
// master = receiver, slave = consumer.
interface uart_rx_os_if;
    logic [7:0] Received;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_Done;
    logic       rx_Busy;
    logic       Error;
    logic       par_err;
    logic       overrun;

    modport master (
        output Received, rx_valid, rx_Done, rx_Busy, Error, par_err, overrun,
        input  rx_ack
    );

    modport slave (
        input  Received, rx_valid, rx_Done, rx_Busy, Error, par_err, overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_os_baud_tick.sv
// Prescaler producing the 16x oversampling tick.
//   clk      : board clock
//   rx_rst   : synchronous active-high reset
//   load     : restart the count and latch the divisor selected by baud_sel
//   baud_sel : divisor select, only looked at while load is high
//   tick     : high for one clk when the count reaches DIV-1
module uart_rx_os_baud_tick
    import uart_rx_os_pkg::*;
#(
    parameter int unsigned DIV_W = 10,
    parameter int unsigned DIV_0 = DEF_DIV_0,
    parameter int unsigned DIV_1 = DEF_DIV_1,
    parameter int unsigned DIV_2 = DEF_DIV_2,
    parameter int unsigned DIV_3 = DEF_DIV_3
) (
    input  logic       clk,
    input  logic       rx_rst,
    input  logic       load,
    input  logic [1:0] baud_sel,
    output logic       tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_sel;

    always_comb begin
        div_sel = DIV_W'(DIV_0);
        case (baud_sel)
            2'd1:    div_sel = DIV_W'(DIV_1);
            2'd2:    div_sel = DIV_W'(DIV_2);
            2'd3:    div_sel = DIV_W'(DIV_3);
            default: div_sel = DIV_W'(DIV_0);
        endcase
    end

    assign tick = (cnt_q == div_q - DIV_W'(1));

    // Divisor is frozen between loads so baud_sel may change mid-frame.
    always_ff @(posedge clk) begin
        if (rx_rst) begin
            cnt_q <= '0;
            div_q <= DIV_W'(DIV_0);
        end else if (load) begin
            cnt_q <= '0;
            div_q <= div_sel;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver: 1 start, 8 data LSB first, optional even parity, 1 stop.
//   clk      : board clock
//   rx_rst   : synchronous active-high reset
//   rx_en    : 0 holds the receiver idle and aborts any frame in progress
//   baud_sel : divisor select, latched at start detection
//   rx_data  : asynchronous serial input, idle high
//   bus      : holding register / status bus (master side)
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter bit          PARITY_EN = 1'b0,
    parameter int unsigned DIV_W     = 10,
    parameter int unsigned DIV_0     = DEF_DIV_0,
    parameter int unsigned DIV_1     = DEF_DIV_1,
    parameter int unsigned DIV_2     = DEF_DIV_2,
    parameter int unsigned DIV_3     = DEF_DIV_3
) (
    input  logic               clk,
    input  logic               rx_rst,
    input  logic               rx_en,
    input  logic [1:0]         baud_sel,
    input  logic               rx_data,
    uart_rx_os_if.master       bus
);

    logic       rx_meta, rxs;
    logic       line_armed;
    rx_state_e  state;
    logic [3:0] sc;
    logic [2:0] idx;
    logic [7:0] sh;
    logic       s7, s8;
    logic       par_bad;
    logic       tick, start_det, vote_now, win_end, vote;

    logic [7:0] recv_q;
    logic       valid_q, done_q, busy_q, err_q, perr_q, ovr_q;

    assign bus.Received = recv_q;
    assign bus.rx_valid = valid_q;
    assign bus.rx_Done  = done_q;
    assign bus.rx_Busy  = busy_q;
    assign bus.Error    = err_q;
    assign bus.par_err  = perr_q;
    assign bus.overrun  = ovr_q;

    always_ff @(posedge clk) begin
        if (rx_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_data;
            rxs     <= rx_meta;
        end
    end

    assign start_det = rx_en && (state == StIdle) && line_armed && !rxs;

    uart_rx_os_baud_tick #(
        .DIV_W (DIV_W),
        .DIV_0 (DIV_0),
        .DIV_1 (DIV_1),
        .DIV_2 (DIV_2),
        .DIV_3 (DIV_3)
    ) u_baud_tick (
        .clk      (clk),
        .rx_rst   (rx_rst),
        .load     (start_det),
        .baud_sel (baud_sel),
        .tick     (tick)
    );

    // Vote on the tick that moves sc to VOTE_SC; window closes on the 15->0 wrap.
    assign vote_now = tick && (sc == 4'(VOTE_SC - 1));
    assign win_end  = tick && (sc == 4'(OVERSAMPLE - 1));
    assign vote     = maj3(s7, s8, rxs);

    always_ff @(posedge clk) begin
        if (rx_rst) begin
            state      <= StIdle;
            line_armed <= 1'b0;
            sc         <= '0;
            idx        <= '0;
            sh         <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            par_bad    <= 1'b0;
            recv_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            perr_q <= 1'b0;
            if (bus.rx_ack) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            if (tick) begin
                sc <= sc + 4'd1;
                if (sc == 4'd6) s7 <= rxs;
                if (sc == 4'd7) s8 <= rxs;
            end

            if (!rx_en) begin
                state      <= StIdle;
                busy_q     <= 1'b0;
                line_armed <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (rxs) begin
                            line_armed <= 1'b1;
                        end else if (line_armed) begin
                            state   <= StStart;
                            busy_q  <= 1'b1;
                            sc      <= '0;
                            par_bad <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (vote_now && vote) begin
                            state  <= StIdle;
                            busy_q <= 1'b0;
                        end else if (win_end) begin
                            state <= StData;
                            idx   <= '0;
                        end
                    end
                    StData: begin
                        if (vote_now) sh[idx] <= vote;
                        if (win_end) begin
                            if (idx == 3'd7) state <= PARITY_EN ? StParity : StStop;
                            else             idx   <= idx + 3'd1;
                        end
                    end
                    StParity: begin
                        if (vote_now) par_bad <= vote ^ (^sh);
                        if (win_end)  state   <= StStop;
                    end
                    StStop: begin
                        // Commit mid-stop so a following start edge is not missed;
                        // disarming stops a held-low break from retriggering.
                        if (vote_now) begin
                            state      <= StIdle;
                            line_armed <= 1'b0;
                            busy_q     <= 1'b0;
                            recv_q     <= sh;
                            valid_q    <= 1'b1;
                            done_q     <= 1'b1;
                            err_q      <= ~vote;
                            perr_q     <= PARITY_EN & par_bad;
                            if (valid_q && !bus.rx_ack) ovr_q <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rx_rst;
    logic       rx_en;
    logic [1:0] baud_sel;
    logic       rxd0, rxd1;
    logic [1:0] ack;

    always #5 clk = ~clk;

    uart_rx_os_if b0 ();
    uart_rx_os_if b1 ();
    assign b0.rx_ack = ack[0];
    assign b1.rx_ack = ack[1];

    uart_rx_os #(
        .PARITY_EN (1'b0), .DIV_W (10), .DIV_0 (4), .DIV_1 (5), .DIV_2 (6), .DIV_3 (7)
    ) dut0 (
        .clk (clk), .rx_rst (rx_rst), .rx_en (rx_en), .baud_sel (baud_sel),
        .rx_data (rxd0), .bus (b0)
    );

    uart_rx_os #(
        .PARITY_EN (1'b1), .DIV_W (10), .DIV_0 (4), .DIV_1 (5), .DIV_2 (6), .DIV_3 (7)
    ) dut1 (
        .clk (clk), .rx_rst (rx_rst), .rx_en (rx_en), .baud_sel (baud_sel),
        .rx_data (rxd1), .bus (b1)
    );

    logic [7:0] recv_w [2];
    logic       valid_w [2];
    logic       ovr_w [2];
    logic       busy_w [2];
    assign recv_w[0] = b0.Received;  assign recv_w[1] = b1.Received;
    assign valid_w[0] = b0.rx_valid; assign valid_w[1] = b1.rx_valid;
    assign ovr_w[0] = b0.overrun;    assign ovr_w[1] = b1.overrun;
    assign busy_w[0] = b0.rx_Busy;   assign busy_w[1] = b1.rx_Busy;

    // Commit events observed on each DUT.
    typedef struct {
        logic [7:0] d;
        logic       e;
        logic       pe;
        logic       busy;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    always @(negedge clk) begin
        if (b0.rx_Done) q0.push_back('{b0.Received, b0.Error, b0.par_err, b0.rx_Busy});
        if (b1.rx_Done) q1.push_back('{b1.Received, b1.Error, b1.par_err, b1.rx_Busy});
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sync_drv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic v, input int n);
        if (w) rxd1 = v; else rxd0 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_clks(input logic [1:0] sel);
        return 16 * (4 + int'(sel));
    endfunction

    // Serial frame onto DUT w; DUT 1 expects a parity bit, DUT 0 does not.
    task automatic send(input bit w, input logic [7:0] d, input logic [1:0] sel,
                        input logic pbit, input logic stop, input bit scr);
        int bt;
        bt = bit_clks(sel);
        baud_sel = sel;
        drive(w, 1'b0, bt);
        if (scr) baud_sel = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) drive(w, d[i], bt);
        if (w) drive(w, pbit, bt);
        drive(w, stop, bt);
        if (w) rxd1 = 1'b1; else rxd0 = 1'b1;
    endtask

    task automatic check_event(input bit w, input logic [7:0] d, input logic e,
                               input logic pe, input string tag);
        int  n;
        ev_t ev;
        n = w ? q1.size() : q0.size();
        check({tag, ".events"}, n, 1);
        if (n > 0) begin
            ev = w ? q1.pop_front() : q0.pop_front();
            check({tag, ".Received"}, ev.d, d);
            check({tag, ".Error"}, ev.e, e);
            check({tag, ".par_err"}, ev.pe, pe);
            check({tag, ".busy_at_done"}, ev.busy, 0);
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic pulse_ack(input bit w);
        ack[w] = 1'b1;
        sync_drv();
        ack[w] = 1'b0;
    endtask

    typedef struct {
        bit         w;
        logic [1:0] sel;
        logic [7:0] d;
        logic       pbit;
        logic       stop;
        logic       exp_err;
        logic       exp_perr;
    } vec_t;

    vec_t vt [7];
    bit   m_valid [2];
    bit   m_ovr [2];

    initial begin
        int n;
        bit got;

        vt[0] = '{1'b0, 2'd0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 2'd1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 2'd2, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 2'd3, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 2'd3, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b1, 2'd1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0};

        rx_rst = 1'b1; rx_en = 1'b1; baud_sel = 2'd0;
        rxd0 = 1'b1; rxd1 = 1'b1; ack = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.Received", b0.Received, 0);
        check("reset.rx_valid", b0.rx_valid, 0);
        check("reset.rx_Done", b0.rx_Done, 0);
        check("reset.rx_Busy", b0.rx_Busy, 0);
        check("reset.Error", b0.Error, 0);
        check("reset.par_err", b1.par_err, 0);
        check("reset.overrun", b0.overrun, 0);
        sync_drv();
        rx_rst = 1'b0;
        repeat (4) sync_drv();

        for (int k = 0; k < 7; k++) begin
            send(vt[k].w, vt[k].d, vt[k].sel, vt[k].pbit, vt[k].stop, 1'b0);
            drive(vt[k].w, 1'b1, 2 * bit_clks(vt[k].sel));
            @(negedge clk);
            check_event(vt[k].w, vt[k].d, vt[k].exp_err, vt[k].exp_perr,
                        $sformatf("vec%0d", k));
            check($sformatf("vec%0d.rx_valid", k), valid_w[vt[k].w], 1);
            check($sformatf("vec%0d.rx_Busy", k), busy_w[vt[k].w], 0);
            sync_drv();
            pulse_ack(vt[k].w);
            @(negedge clk);
            check($sformatf("vec%0d.ack_clears", k), valid_w[vt[k].w], 0);
            sync_drv();
        end

        // Pin edge to rx_Done latency: 3 + 153*DIV clks.
        for (int s = 0; s < 3; s += 2) begin
            n = 0;
            got = 1'b0;
            fork
                send(1'b0, 8'h55, 2'(s), 1'b0, 1'b1, 1'b0);
                begin
                    for (int k = 0; k < 3000 && !got; k++) begin
                        @(posedge clk);
                        n++;
                        @(negedge clk);
                        if (b0.rx_Done) got = 1'b1;
                    end
                end
            join
            check($sformatf("latency.sel%0d", s), n, 3 + 153 * (4 + s));
            @(negedge clk);
            check_event(1'b0, 8'h55, 1'b0, 1'b0, "latency");
            sync_drv();
            pulse_ack(1'b0);
        end

        // Short low glitch: start seen, then rejected by the vote.
        baud_sel = 2'd0;
        drive(1'b0, 1'b0, 5);
        @(negedge clk);
        check("glitch.busy_on_start", b0.rx_Busy, 1);
        sync_drv();
        drive(1'b0, 1'b0, 14);
        drive(1'b0, 1'b1, 200);
        @(negedge clk);
        check("glitch.no_done", q0.size(), 0);
        check("glitch.rx_Busy", b0.rx_Busy, 0);
        check("glitch.rx_valid", b0.rx_valid, 0);
        sync_drv();

        // Break: framing error once, then no retrigger while held low.
        drive(1'b0, 1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'h3C;
            drive(1'b0, v[i], 64);
        end
        drive(1'b0, 1'b0, 21 * 64);
        @(negedge clk);
        check_event(1'b0, 8'h3C, 1'b1, 1'b0, "break");
        check("break.rx_Busy", b0.rx_Busy, 0);
        sync_drv();
        drive(1'b0, 1'b1, 2 * 64);
        @(negedge clk);
        check("break.no_retrigger", q0.size(), 0);
        sync_drv();
        pulse_ack(1'b0);
        send(1'b0, 8'h81, 2'd1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_event(1'b0, 8'h81, 1'b0, 1'b0, "break.recover");
        sync_drv();
        pulse_ack(1'b0);

        // Back-to-back frames without ack -> overrun.
        send(1'b0, 8'h11, 2'd2, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'h22, 2'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("ovr.events", q0.size(), 2);
        check("ovr.Received", b0.Received, 8'h22);
        check("ovr.rx_valid", b0.rx_valid, 1);
        check("ovr.overrun", b0.overrun, 1);
        q0.delete();
        sync_drv();
        pulse_ack(1'b0);
        @(negedge clk);
        check("ovr.ack_valid", b0.rx_valid, 0);
        check("ovr.ack_overrun", b0.overrun, 0);
        sync_drv();

        // rx_en low: line ignored.
        rx_en = 1'b0;
        send(1'b0, 8'h42, 2'd0, 1'b0, 1'b1, 1'b0);
        rx_en = 1'b1;
        drive(1'b0, 1'b1, 64);
        @(negedge clk);
        check("rx_en.no_done", q0.size(), 0);
        check("rx_en.rx_valid", b0.rx_valid, 0);
        sync_drv();

        // Reset mid-DATA; holding register cleared, partial frame dropped.
        send(1'b0, 8'h99, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_event(1'b0, 8'h99, 1'b0, 1'b0, "pre_rst");
        sync_drv();
        fork
            send(1'b0, 8'hFF, 2'd0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (3 * 64) @(posedge clk);
                @(negedge clk);
                check("rst.busy_before", b0.rx_Busy, 1);
                sync_drv();
                rx_rst = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("rst.Received", b0.Received, 0);
                check("rst.rx_valid", b0.rx_valid, 0);
                check("rst.rx_Busy", b0.rx_Busy, 0);
                check("rst.overrun", b0.overrun, 0);
                sync_drv();
                rx_rst = 1'b0;
            end
        join
        drive(1'b0, 1'b1, 64);
        @(negedge clk);
        check("rst.no_done", q0.size(), 0);
        sync_drv();
        send(1'b0, 8'h5A, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_event(1'b0, 8'h5A, 1'b0, 1'b0, "post_rst");
        check("post_rst.rx_valid", b0.rx_valid, 1);
        sync_drv();

        // Random frames against a byte-level model of the receiver.
        pulse_ack(1'b0);
        pulse_ack(1'b1);
        m_valid[0] = 0; m_valid[1] = 0; m_ovr[0] = 0; m_ovr[1] = 0;
        for (int r = 0; r < 16; r++) begin
            bit         w;
            logic [1:0] sel;
            logic [7:0] d;
            logic       stop, pbit;
            int         gap;
            w    = 1'($urandom_range(0, 1));
            sel  = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pbit = 1'($urandom_range(0, 1));
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send(w, d, sel, pbit, stop, 1'($urandom_range(0, 1)));
            @(negedge clk);
            check_event(w, d, ~stop, w ? (pbit ^ (^d)) : 1'b0, $sformatf("rand%0d", r));
            m_ovr[w]   = m_ovr[w] | m_valid[w];
            m_valid[w] = 1;
            check($sformatf("rand%0d.rx_valid", r), valid_w[w], m_valid[w]);
            check($sformatf("rand%0d.overrun", r), ovr_w[w], m_ovr[w]);
            check($sformatf("rand%0d.Received", r), recv_w[w], d);
            sync_drv();
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack(w);
                m_valid[w] = 0;
                m_ovr[w]   = 0;
                @(negedge clk);
                check($sformatf("rand%0d.ack_valid", r), valid_w[w], 0);
                check($sformatf("rand%0d.ack_overrun", r), ovr_w[w], 0);
                sync_drv();
            end
            if (gap > 0) drive(w, 1'b1, gap * bit_clks(sel));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
